// File: rtl/lacc_mem_responder_pkg.sv
// Shared types and constants for the lacc_data read responder and its host-fill write port.
package lacc_mem_responder_pkg;

    localparam int unsigned LACC_DATA_WIDTH = 32;
    localparam int unsigned LACC_ADDR_WIDTH = 32;
    localparam int unsigned LACC_STRB_WIDTH = LACC_DATA_WIDTH / 8;

    localparam logic [1:0] LACC_SIZE_BYTE    = 2'd0;
    localparam logic [1:0] LACC_SIZE_HALF    = 2'd1;
    localparam logic [1:0] LACC_SIZE_WORD    = 2'd2;
    localparam logic [1:0] LACC_SIZE_ILLEGAL = 2'd3;

    typedef enum logic {
        RR_READ  = 1'b0,
        RR_WRITE = 1'b1
    } rr_side_e;

    // One response-pipe stage; err also means the returned word is forced to zero.
    typedef struct packed {
        logic valid;
        logic err;
    } rsp_meta_t;

    // Misaligned, illegal-size or beyond-the-bank read request.
    function automatic logic req_is_err(input logic [LACC_ADDR_WIDTH-1:0] addr,
                                        input logic [1:0]                 size,
                                        input int unsigned                mem_words);
        logic bad_align;
        bad_align = ((size == LACC_SIZE_WORD) && (addr[1:0] != 2'b00)) ||
                    ((size == LACC_SIZE_HALF) && addr[0]) ||
                    (size == LACC_SIZE_ILLEGAL);
        return bad_align || ({2'b00, addr[LACC_ADDR_WIDTH-1:2]} >= 32'(mem_words));
    endfunction

endpackage

// File: rtl/lacc_mem_responder_if.sv
// Read request/response channel plus host write channel between fetcher/host and responder.
interface lacc_mem_responder_if;
    import lacc_mem_responder_pkg::*;

    logic                       lacc_data_valid;
    logic [LACC_ADDR_WIDTH-1:0] lacc_data_addr;
    logic [1:0]                 lacc_data_size;
    logic                       lacc_data_ready;
    logic                       lacc_drsp_valid;
    logic [LACC_DATA_WIDTH-1:0] lacc_drsp_rdata;
    logic                       wr_valid;
    logic [LACC_ADDR_WIDTH-1:0] wr_addr;
    logic [LACC_DATA_WIDTH-1:0] wr_data;
    logic [LACC_STRB_WIDTH-1:0] wr_strb;
    logic                       wr_ready;

    modport master (
        output lacc_data_valid, lacc_data_addr, lacc_data_size,
        output wr_valid, wr_addr, wr_data, wr_strb,
        input  lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata, wr_ready
    );

    modport slave (
        input  lacc_data_valid, lacc_data_addr, lacc_data_size,
        input  wr_valid, wr_addr, wr_data, wr_strb,
        output lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata, wr_ready
    );

endinterface

// File: rtl/lacc_mem_responder_bank.sv
// Single-port word SRAM with byte write strobes and a one-cycle registered read port.
module lacc_mem_responder_bank
    import lacc_mem_responder_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [AW-1:0]              addr,
    input  logic [LACC_DATA_WIDTH-1:0] wdata,
    input  logic [LACC_STRB_WIDTH-1:0] strb,
    output logic [LACC_DATA_WIDTH-1:0] rdata
);

    logic [LACC_DATA_WIDTH-1:0] mem_q [WORDS];
    logic [LACC_DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Read port holds its last word until the next read access.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            for (int b = 0; b < int'(LACC_STRB_WIDTH); b++) begin
                if (strb[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lacc_mem_responder.sv
// Responder for the lacc_data read channel: round-robin read/write arbitration onto one SRAM
// port, request error checking, in-order response pipe and sticky error flag. READ_LAT >= 2.
module lacc_mem_responder
    import lacc_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned READ_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lacc_mem_responder_if.slave  bus,
    output logic                 err,
    input  logic                 err_clr
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned PIPE = READ_LAT - 1;

    rr_side_e                   rr_last_q, rr_last_d;
    logic                       rd_gnt, wr_gnt;
    logic                       rd_err, wr_in_range;
    logic                       bank_en;
    logic [AW-1:0]              bank_addr;
    logic [LACC_DATA_WIDTH-1:0] bank_rdata;
    rsp_meta_t                  meta_q [PIPE];
    rsp_meta_t                  meta_d [PIPE];
    logic [LACC_DATA_WIDTH-1:0] data_q [PIPE];
    logic [LACC_DATA_WIDTH-1:0] data_d [PIPE];
    logic                       drsp_valid_q, drsp_valid_d;
    logic                       err_q, err_d;
    logic                       unused_wr_lsb;

    // Arbiter: uncontested side wins; on contention the side not served last time wins.
    always_comb begin
        rr_last_d = rr_last_q;
        rd_gnt    = 1'b0;
        wr_gnt    = 1'b0;
        if (rst_n) begin
            if (bus.lacc_data_valid && bus.wr_valid) begin
                if (rr_last_q == RR_WRITE) begin
                    rd_gnt    = 1'b1;
                    rr_last_d = RR_READ;
                end else begin
                    wr_gnt    = 1'b1;
                    rr_last_d = RR_WRITE;
                end
            end else begin
                rd_gnt = bus.lacc_data_valid;
                wr_gnt = bus.wr_valid;
            end
        end
    end

    assign rd_err        = req_is_err(bus.lacc_data_addr, bus.lacc_data_size, MEM_WORDS);
    assign wr_in_range   = {2'b00, bus.wr_addr[LACC_ADDR_WIDTH-1:2]} < 32'(MEM_WORDS);
    assign unused_wr_lsb = ^bus.wr_addr[1:0];

    // Faulty reads and out-of-range writes are accepted but never touch the array.
    assign bank_en   = (rd_gnt && !rd_err) || (wr_gnt && wr_in_range);
    assign bank_addr = wr_gnt ? bus.wr_addr[AW+1:2] : bus.lacc_data_addr[AW+1:2];

    lacc_mem_responder_bank #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (wr_gnt),
        .addr  (bank_addr),
        .wdata (bus.wr_data),
        .strb  (bus.wr_strb),
        .rdata (bank_rdata)
    );

    // Response pipe; faulty requests are zeroed when the bank word is first captured.
    always_comb begin
        meta_d[0].valid = rd_gnt;
        meta_d[0].err   = rd_err;
        for (int unsigned i = 1; i < PIPE; i++) begin
            meta_d[i] = meta_q[i-1];
        end
        for (int unsigned i = 0; i < PIPE; i++) begin
            data_d[i] = data_q[i];
        end
        if (meta_q[0].valid) begin
            data_d[0] = meta_q[0].err ? '0 : bank_rdata;
        end
        for (int unsigned i = 1; i < PIPE; i++) begin
            if (meta_q[i].valid) begin
                data_d[i] = data_q[i-1];
            end
        end
        drsp_valid_d = meta_q[PIPE-1].valid;
        err_d        = (err_q && !err_clr) || (meta_q[PIPE-1].valid && meta_q[PIPE-1].err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q    <= RR_WRITE;
            drsp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < PIPE; i++) begin
                meta_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rr_last_q    <= rr_last_d;
            drsp_valid_q <= drsp_valid_d;
            err_q        <= err_d;
            for (int unsigned i = 0; i < PIPE; i++) begin
                meta_q[i] <= meta_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.lacc_data_ready = rd_gnt;
    assign bus.wr_ready        = wr_gnt;
    assign bus.lacc_drsp_valid = drsp_valid_q;
    assign bus.lacc_drsp_rdata = data_q[PIPE-1];
    assign err                 = err_q;

endmodule

// File: tb/tb_lacc_mem_responder.sv
// Directed bench for lacc_mem_responder: read vector table plus hand-written multi-cycle sequences.
module tb_lacc_mem_responder;
    import lacc_mem_responder_pkg::*;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned READ_LAT  = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] rdata;
        logic        err;
    } rvec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic err;
    logic err_clr;
    int   checks = 0;
    int   errors = 0;
    int   rsp_cnt;
    rvec_t vecs [14];

    lacc_mem_responder_if bus();

    lacc_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, required to finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lacc_data_valid = 1'b0;
        bus.lacc_data_addr  = '0;
        bus.lacc_data_size  = LACC_SIZE_WORD;
        bus.wr_valid        = 1'b0;
        bus.wr_addr         = '0;
        bus.wr_data         = '0;
        bus.wr_strb         = '0;
        err_clr             = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = addr;
        bus.wr_data  = data;
        bus.wr_strb  = strb;
        #1;
        chk($sformatf("wr_ready@%h", addr), 32'(bus.wr_ready), 32'd1);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    // Single read: accepted at T, silent at T+1, strobe at T+2, held at T+3; clears err if set.
    task automatic read_chk(input string name, input rvec_t v);
        bus.lacc_data_valid = 1'b1;
        bus.lacc_data_addr  = v.addr;
        bus.lacc_data_size  = v.size;
        #1;
        chk({name, "_ready"}, 32'(bus.lacc_data_ready), 32'd1);
        tick();
        bus.lacc_data_valid = 1'b0;
        chk({name, "_early_valid"}, 32'(bus.lacc_drsp_valid), 32'd0);
        chk({name, "_early_err"}, 32'(err), 32'd0);
        tick();
        chk({name, "_valid"}, 32'(bus.lacc_drsp_valid), 32'd1);
        chk({name, "_rdata"}, bus.lacc_drsp_rdata, v.rdata);
        chk({name, "_err"}, 32'(err), 32'(v.err));
        tick();
        chk({name, "_valid_drop"}, 32'(bus.lacc_drsp_valid), 32'd0);
        chk({name, "_rdata_hold"}, bus.lacc_drsp_rdata, v.rdata);
        chk({name, "_err_sticky"}, 32'(err), 32'(v.err));
        if (v.err) begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            chk({name, "_err_clr"}, 32'(err), 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0005, LACC_SIZE_BYTE,    32'h0706_0504, 1'b0};
        vecs[1]  = '{32'h0000_0003, LACC_SIZE_HALF,    32'h0000_0000, 1'b1};
        vecs[2]  = '{32'h0000_0006, LACC_SIZE_HALF,    32'h0706_0504, 1'b0};
        vecs[3]  = '{32'h0000_0008, LACC_SIZE_WORD,    32'h0B0A_0908, 1'b0};
        vecs[4]  = '{32'h0000_000A, LACC_SIZE_WORD,    32'h0000_0000, 1'b1};
        vecs[5]  = '{32'h0000_000C, LACC_SIZE_ILLEGAL, 32'h0000_0000, 1'b1};
        vecs[6]  = '{32'h0000_1000, LACC_SIZE_WORD,    32'h0000_0000, 1'b1};
        vecs[7]  = '{32'h0000_0FFC, LACC_SIZE_WORD,    32'hA5A5_5A5A, 1'b0};
        vecs[8]  = '{32'h0000_1001, LACC_SIZE_BYTE,    32'h0000_0000, 1'b1};
        vecs[9]  = '{32'hFFFF_FFFC, LACC_SIZE_WORD,    32'h0000_0000, 1'b1};
        vecs[10] = '{32'h0000_000F, LACC_SIZE_BYTE,    32'h0F0E_0D0C, 1'b0};
        vecs[11] = '{32'h0000_0010, LACC_SIZE_WORD,    32'h11AD_11EF, 1'b0};
        vecs[12] = '{32'h0000_0FFF, LACC_SIZE_BYTE,    32'hA5A5_5A5A, 1'b0};
        vecs[13] = '{32'h0000_0002, LACC_SIZE_HALF,    32'h0302_0100, 1'b0};

        // Reset with both valids high: nothing may be granted.
        idle();
        rst_n = 1'b0;
        bus.lacc_data_valid = 1'b1;
        bus.wr_valid        = 1'b1;
        tick();
        tick();
        chk("rst_rd_ready", 32'(bus.lacc_data_ready), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_drsp_valid", 32'(bus.lacc_drsp_valid), 32'd0);
        chk("rst_drsp_rdata", bus.lacc_drsp_rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        idle();
        rst_n = 1'b1;
        tick();

        for (int w = 0; w < 4; w++) begin
            do_write(32'(4 * w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF);
        end
        do_write(32'h0000_0FFC, 32'hA5A5_5A5A, 4'hF);
        do_write(32'h0000_0010, 32'h1111_1111, 4'hF);
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'b0101);
        do_write(32'h0000_1000, 32'hFFFF_FFFF, 4'hF);

        // Back-to-back word reads 0x0, 0x4, 0x8.
        bus.lacc_data_valid = 1'b1;
        bus.lacc_data_size  = LACC_SIZE_WORD;
        bus.lacc_data_addr  = 32'h0;
        #1;
        chk("b2b_ready0", 32'(bus.lacc_data_ready), 32'd1);
        tick();
        chk("b2b_valid_t1", 32'(bus.lacc_drsp_valid), 32'd0);
        bus.lacc_data_addr = 32'h4;
        tick();
        chk("b2b_valid_t2", 32'(bus.lacc_drsp_valid), 32'd1);
        chk("b2b_rdata_t2", bus.lacc_drsp_rdata, 32'h0302_0100);
        bus.lacc_data_addr = 32'h8;
        tick();
        chk("b2b_valid_t3", 32'(bus.lacc_drsp_valid), 32'd1);
        chk("b2b_rdata_t3", bus.lacc_drsp_rdata, 32'h0706_0504);
        bus.lacc_data_valid = 1'b0;
        tick();
        chk("b2b_valid_t4", 32'(bus.lacc_drsp_valid), 32'd1);
        chk("b2b_rdata_t4", bus.lacc_drsp_rdata, 32'h0B0A_0908);
        tick();
        chk("b2b_valid_t5", 32'(bus.lacc_drsp_valid), 32'd0);

        for (int i = 0; i < 14; i++) begin
            read_chk($sformatf("vec%0d", i), vecs[i]);
        end

        // Clear requested in the same cycle the error is being set: set wins.
        bus.lacc_data_valid = 1'b1;
        bus.lacc_data_addr  = 32'h1;
        bus.lacc_data_size  = LACC_SIZE_HALF;
        tick();
        bus.lacc_data_valid = 1'b0;
        err_clr = 1'b1;
        chk("setwin_before", 32'(err), 32'd0);
        tick();
        err_clr = 1'b0;
        chk("setwin_err", 32'(err), 32'd1);
        chk("setwin_rdata", bus.lacc_drsp_rdata, 32'd0);
        tick();
        chk("setwin_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("setwin_clr", 32'(err), 32'd0);

        // Both valids for 8 cycles: grants alternate R,W,... starting with read.
        rsp_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            chk($sformatf("arb_drsp_valid_c%0d", c), 32'(bus.lacc_drsp_valid),
                32'((c >= 2) && (c <= 8) && (c % 2 == 0)));
            if (bus.lacc_drsp_valid) begin
                rsp_cnt++;
                chk($sformatf("arb_rdata_c%0d", c), bus.lacc_drsp_rdata, 32'h0302_0100);
            end
            if (c < 8) begin
                bus.lacc_data_valid = 1'b1;
                bus.lacc_data_addr  = 32'h0;
                bus.lacc_data_size  = LACC_SIZE_WORD;
                bus.wr_valid        = 1'b1;
                bus.wr_addr         = 32'h20;
                bus.wr_data         = 32'hC0DE_0000 + 32'(c);
                bus.wr_strb         = 4'hF;
                #1;
                chk($sformatf("arb_rd_ready_c%0d", c), 32'(bus.lacc_data_ready), 32'(c % 2 == 0));
                chk($sformatf("arb_wr_ready_c%0d", c), 32'(bus.wr_ready), 32'(c % 2 == 1));
            end else begin
                idle();
            end
            @(posedge clk);
            #1;
        end
        chk("arb_rsp_count", 32'(rsp_cnt), 32'd4);
        read_chk("arb_last_write", '{32'h20, LACC_SIZE_WORD, 32'hC0DE_0007, 1'b0});

        // Two reads in flight (second faulty), then a one-cycle reset.
        bus.lacc_data_valid = 1'b1;
        bus.lacc_data_addr  = 32'h0;
        bus.lacc_data_size  = LACC_SIZE_WORD;
        tick();
        bus.lacc_data_addr = 32'h2;
        #1;
        chk("midrst_ready2", 32'(bus.lacc_data_ready), 32'd1);
        tick();
        rst_n = 1'b0;
        bus.lacc_data_addr = 32'h4;
        bus.wr_valid       = 1'b1;
        bus.wr_addr        = 32'h0;
        bus.wr_strb        = 4'hF;
        #1;
        chk("midrst_rd_ready", 32'(bus.lacc_data_ready), 32'd0);
        chk("midrst_wr_ready", 32'(bus.wr_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("midrst_valid_k%0d", k), 32'(bus.lacc_drsp_valid), 32'd0);
            chk($sformatf("midrst_err_k%0d", k), 32'(err), 32'd0);
            tick();
        end
        read_chk("post_rst_word0", '{32'h0, LACC_SIZE_WORD, 32'h0302_0100, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
